// File: rtl/matrix_operand_streamer.sv
// matrix_operand_streamer: walks row/col/k of an NxN product, reads A/B RAMs and streams operand pairs.
module matrix_operand_streamer #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        matrix_size,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_rdata,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_rdata,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              out_last,
    output logic              out_end,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = 2 * DATA_W + 2;
    state_t state, state_nx;
    logic [3:0] n, n1, row, col, k;
    logic inflight, tag_last, tag_end, issue, last_now, end_now, pop;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [EW-1:0] head;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign n1       = n - 1'b1;
    assign last_now = k == n1;
    assign end_now  = last_now && col == n1 && row == n1;
    // credit check counts the read already in flight so the FIFO can never overflow
    assign issue    = state == ISSUE && int'(count) + int'(inflight) < FIFO_DEPTH;
    assign head     = mem[rd_ptr];
    assign pop      = out_valid && out_ready;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? (matrix_size != 0 ? ISSUE : DONE) : IDLE;
            ISSUE:   state_nx = issue && end_now ? DRAIN : ISSUE;
            DRAIN:   state_nx = pop && head[EW-2] ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        a_rd_en   = issue;
        b_rd_en   = issue;
        a_addr    = ADDR_W'(row) * ADDR_W'(n) + ADDR_W'(k);
        b_addr    = ADDR_W'(k) * ADDR_W'(n) + ADDR_W'(col);
        out_valid = count != 0;
        out_a     = out_valid ? head[2*DATA_W-1:DATA_W] : '0;
        out_b     = out_valid ? head[DATA_W-1:0] : '0;
        out_last  = out_valid && head[EW-1];
        out_end   = out_valid && head[EW-2];
        busy      = state == ISSUE || state == DRAIN;
        done      = state == DONE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            n        <= '0;
            row      <= '0;
            col      <= '0;
            k        <= '0;
            inflight <= 1'b0;
            tag_last <= 1'b0;
            tag_end  <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) {tag_last, tag_end} <= {last_now, end_now};
            if (state == IDLE && start) begin
                n   <= matrix_size;
                row <= '0;
                col <= '0;
                k   <= '0;
            end else if (issue) begin
                k <= last_now ? '0 : k + 1'b1;
                if (last_now) col <= col == n1 ? '0 : col + 1'b1;
                if (last_now && col == n1) row <= row + 1'b1;
            end
            if (inflight) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(inflight) - CW'(pop);
        end
    always_ff @(posedge clk)
        if (inflight) mem[wr_ptr] <= {tag_last, tag_end, a_rdata, b_rdata};
endmodule

// File: tb/tb_matrix_operand_streamer.sv
// tb_matrix_operand_streamer: directed passes with a queued scoreboard checked by an independent monitor.
module tb_matrix_operand_streamer;
    typedef struct {logic [31:0] a, b; logic l, e;} beat_t;
    logic clk = 0, rst = 1, start = 0, out_ready = 1;
    logic [3:0] matrix_size = 0;
    logic a_rd_en, b_rd_en, out_last, out_end, out_valid, busy, done;
    logic [7:0] a_addr, b_addr;
    logic [31:0] a_rdata, b_rdata, out_a, out_b;
    logic [31:0] amem [256];
    logic [31:0] bmem [256];
    beat_t exp_q[$];
    logic [15:0] addr_q[$];
    int tests = 0, fails = 0, beats = 0, lasts = 0, cyc = 0;
    int start_cyc = 0, first_cyc = 0, last_cyc = 0, max_addr = 0;
    logic exp_busy = 0, exp_done = 0, stalled = 0, rdy_mode = 0;
    logic [65:0] held;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int ta [8] = '{1, 2, 1, 2, 3, 4, 3, 4};
    int tb [8] = '{5, 7, 6, 8, 5, 7, 6, 8};
    int taa [8] = '{0, 1, 0, 1, 2, 3, 2, 3};
    int tba [8] = '{0, 2, 1, 3, 0, 2, 1, 3};

    matrix_operand_streamer dut (
        .clk(clk), .rst(rst), .start(start), .matrix_size(matrix_size),
        .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rdata(a_rdata),
        .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rdata(b_rdata),
        .out_a(out_a), .out_b(out_b), .out_last(out_last), .out_end(out_end),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) begin
        if (a_rd_en) a_rdata <= amem[a_addr];
        if (b_rd_en) b_rdata <= bmem[b_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode) begin
            out_ready = pat[cyc % 4];
        end
    end

    always @(negedge clk) begin
        logic nb, nd, xfer;
        beat_t e;
        if (rst) begin
            exp_busy = 0;
            exp_done = 0;
            stalled = 0;
        end else begin
            chk("done", done, exp_done);
            chk("busy", busy, exp_busy);
            chk("rd_en_pair", b_rd_en, a_rd_en);
            chk("fifo_count_bound", dut.count <= 4, 1);
            if (a_rd_en) begin
                chk("addr_avail", addr_q.size() > 0, 1);
                if (a_addr > max_addr) max_addr = a_addr;
                if (addr_q.size() > 0) chk("addr", {a_addr, b_addr}, addr_q.pop_front());
            end
            if (out_valid && stalled) chk("stall_stable", {out_last, out_end, out_a, out_b}, held);
            stalled = out_valid && !out_ready;
            held = {out_last, out_end, out_a, out_b};
            xfer = out_valid && out_ready;
            if (xfer) begin
                chk("beat_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_a", out_a, e.a);
                    chk("out_b", out_b, e.b);
                    chk("out_tags", {out_last, out_end}, {e.l, e.e});
                end
                beats++;
                if (out_last) lasts++;
                if (beats == 1) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (!exp_busy && !exp_done && start) start_cyc = cyc;
            nd = (xfer && out_end) || (!exp_busy && !exp_done && start && matrix_size == 0);
            nb = (!exp_busy && !exp_done && start && matrix_size != 0) ? 1'b1 : (xfer && out_end) ? 1'b0 : exp_busy;
            exp_busy = nb;
            exp_done = nd;
        end
    end

    task automatic push_hand();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{ta[i], tb[i], i % 2 == 1, i == 7});
            addr_q.push_back({taa[i][7:0], tba[i][7:0]});
        end
    endtask

    task automatic push_model(input int n);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                for (int k = 0; k < n; k++) begin
                    int ai = r * n + k, bi = k * n + c;
                    exp_q.push_back('{amem[ai], bmem[bi], k == n - 1, r == n - 1 && c == n - 1 && k == n - 1});
                    addr_q.push_back({ai[7:0], bi[7:0]});
                end
    endtask

    task automatic kick(input int n);
        beats = 0;
        lasts = 0;
        max_addr = 0;
        @(posedge clk);
        #1 start = 1;
        matrix_size = n[3:0];
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic finish_run(input int n, input int budget, input bit timing);
        int t = 0;
        while (!done && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", done, 1);
        chk("beats", beats, n * n * n);
        chk("lasts", lasts, n * n);
        chk("exp_left", exp_q.size(), 0);
        chk("addr_left", addr_q.size(), 0);
        if (timing) begin
            chk("first_latency", first_cyc - start_cyc, 3);
            chk("contiguous", last_cyc - first_cyc, n * n * n - 1);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {a_rd_en, b_rd_en, a_addr, b_addr, out_last, out_end, out_valid, busy, done}, 0);
        chk({tag, "_data"}, {out_a, out_b}, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            amem[i] = i + 1;
            bmem[i] = i < 4 ? i + 5 : 32'h1_0000 + i;
        end
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        rst = 0;
        // test 1: N=2 hand table, full ready
        push_hand();
        kick(2);
        finish_run(2, 100, 1);
        // test 2: ready toggling 1,0,0,1
        push_hand();
        rdy_mode = 1;
        kick(2);
        finish_run(2, 200, 0);
        rdy_mode = 0;
        out_ready = 1;
        // test 3: N=3
        push_model(3);
        kick(3);
        finish_run(3, 200, 1);
        // test 4: N=0 produces only a done pulse
        kick(0);
        finish_run(0, 10, 0);
        // test 5: N=15 full pass
        push_model(15);
        kick(15);
        finish_run(15, 5000, 1);
        chk("max_addr", max_addr, 224);
        // test 6: reset mid-pass with two beats queued, then a clean N=2 pass
        out_ready = 0;
        push_model(4);
        kick(4);
        repeat (3) @(posedge clk);
        #1 chk("fifo_two", dut.count, 2);
        chk("valid_pre_rst", out_valid, 1);
        #1 rst = 1;
        #1 chk_zero("midrst");
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #1 chk_zero("rst_hold");
        rst = 0;
        out_ready = 1;
        push_hand();
        kick(2);
        finish_run(2, 100, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
